// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared constants, state encoding and size helpers for the
//                load/store unit controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RISC-V funct3 size codes for loads and stores
    localparam logic [2:0] FN3_B  = 3'b000;
    localparam logic [2:0] FN3_H  = 3'b001;
    localparam logic [2:0] FN3_W  = 3'b010;
    localparam logic [2:0] FN3_BU = 3'b100;
    localparam logic [2:0] FN3_HU = 3'b101;

    // Byte lanes per bus word
    localparam int NUM_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_t;

    // Access size in bytes; only meaningful for legal fn3 codes
    function automatic logic [2:0] fn3_bytes(input logic [2:0] fn3);
        logic [2:0] n;
        case (fn3)
            FN3_B, FN3_BU: n = 3'd1;
            FN3_H, FN3_HU: n = 3'd2;
            default:       n = 3'd4;
        endcase
        return n;
    endfunction

    // Right-aligned byte mask (1<<n)-1 for the access size
    function automatic logic [NUM_LANES-1:0] fn3_mask(input logic [2:0] fn3);
        logic [NUM_LANES-1:0] m;
        case (fn3)
            FN3_B, FN3_BU: m = 4'b0001;
            FN3_H, FN3_HU: m = 4'b0011;
            default:       m = 4'b1111;
        endcase
        return m;
    endfunction

    // Exactly one of load/store, with a size code valid for that direction
    function automatic logic fn3_legal(input logic is_load, input logic is_store,
                                       input logic [2:0] fn3);
        logic ok;
        ok = 1'b0;
        if (is_load && !is_store) begin
            ok = fn3 inside {FN3_B, FN3_H, FN3_W, FN3_BU, FN3_HU};
        end else if (is_store && !is_load) begin
            ok = fn3 inside {FN3_B, FN3_H, FN3_W};
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational byte-enable, store-lane and load-lane steering
//                for one bus beat of a possibly word-crossing access.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]           i_fn3,
    input  logic [1:0]           i_off,
    input  logic                 i_beat,
    input  logic [XLEN-1:0]      i_wdata,
    input  logic [XLEN-1:0]      i_rdata,
    output logic [NUM_LANES-1:0] o_be,
    output logic [XLEN-1:0]      o_wdata,
    output logic [XLEN-1:0]      o_rlane
);

    logic [4:0]             w_shamt;
    logic [2*NUM_LANES-1:0] w_be_wide;
    logic [2*XLEN-1:0]      w_wdata_wide;
    logic [2*XLEN-1:0]      w_rdata_wide;

    // Shift across a double-width window: the low half is beat 0, the high
    // half is what spills into beat 1. For the read side the window is
    // mirrored so the high half is beat 0's contribution.
    assign w_shamt      = {i_off, 3'b000};
    assign w_be_wide    = {{NUM_LANES{1'b0}}, fn3_mask(i_fn3)} << i_off;
    assign w_wdata_wide = {{XLEN{1'b0}}, i_wdata} << w_shamt;
    assign w_rdata_wide = {i_rdata, {XLEN{1'b0}}} >> w_shamt;

    assign o_be    = i_beat ? w_be_wide[2*NUM_LANES-1:NUM_LANES] : w_be_wide[NUM_LANES-1:0];
    assign o_wdata = i_beat ? w_wdata_wide[2*XLEN-1:XLEN]        : w_wdata_wide[XLEN-1:0];
    assign o_rlane = i_beat ? w_rdata_wide[XLEN-1:0]             : w_rdata_wide[2*XLEN-1:XLEN];

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store sequencer between the execute stage and a
//                word-organised data bus; splits word-crossing accesses into
//                two beats and sign/zero-extends load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_fn3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("lsu_ctrl: only XLEN = 32 is supported");
        end
    endgenerate

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_fn3;
    logic [XLEN-1:0]   r_wdata;
    logic              r_load;
    logic              r_store;
    logic              r_err;
    logic [XLEN-1:0]   r_assy;

    logic              w_req_legal;
    logic              w_split;
    logic              w_beat;
    logic [1:0]        w_off;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rlane;
    logic [XLEN-1:0]   w_ext;

    assign w_req_legal = fn3_legal(req_load, req_store, req_fn3);
    assign w_off       = r_addr[1:0];
    assign w_split     = ({2'b00, w_off} + {1'b0, fn3_bytes(r_fn3)}) > 4'd4;
    assign w_base      = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_beat_addr = w_beat ? (w_base + ADDR_W'(NUM_LANES)) : w_base;

    lsu_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .i_fn3   (r_fn3),
        .i_off   (w_off),
        .i_beat  (w_beat),
        .i_wdata (r_wdata),
        .i_rdata (mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rlane (w_rlane)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        mem_req      = 1'b0;
        resp_valid   = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_req_legal ? ST_ISSUE0 : ST_RESP;
                end
            end
            ST_ISSUE0: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    if (r_store) begin
                        w_next_state = w_split ? ST_ISSUE1 : ST_RESP;
                    end else begin
                        w_next_state = ST_WAIT0;
                    end
                end
            end
            ST_WAIT0: begin
                if (mem_rvalid) begin
                    w_next_state = w_split ? ST_ISSUE1 : ST_RESP;
                end
            end
            ST_ISSUE1: begin
                mem_req = 1'b1;
                w_beat  = 1'b1;
                if (mem_gnt) begin
                    w_next_state = r_store ? ST_RESP : ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                w_beat = 1'b1;
                if (mem_rvalid) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the request in IDLE and assemble read lanes in the WAIT states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_fn3   <= '0;
            r_wdata <= '0;
            r_load  <= 1'b0;
            r_store <= 1'b0;
            r_err   <= 1'b0;
            r_assy  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_fn3   <= req_fn3;
                        r_wdata <= req_wdata;
                        r_load  <= req_load;
                        r_store <= req_store;
                        r_err   <= !w_req_legal;
                        r_assy  <= '0;
                    end
                end
                ST_WAIT0: begin
                    if (mem_rvalid) begin
                        r_assy <= w_rlane;
                    end
                end
                ST_WAIT1: begin
                    if (mem_rvalid) begin
                        r_assy <= r_assy | w_rlane;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Load-data extension by size code
    always_comb begin
        case (r_fn3)
            FN3_B:   w_ext = {{(XLEN-8){r_assy[7]}}, r_assy[7:0]};
            FN3_H:   w_ext = {{(XLEN-16){r_assy[15]}}, r_assy[15:0]};
            FN3_BU:  w_ext = {{(XLEN-8){1'b0}}, r_assy[7:0]};
            FN3_HU:  w_ext = {{(XLEN-16){1'b0}}, r_assy[15:0]};
            default: w_ext = r_assy;
        endcase
    end

    // Bus fields are driven only while a beat is being offered so the bus
    // sees zeros otherwise, including straight out of reset.
    assign mem_we    = mem_req & r_store;
    assign mem_be    = mem_req ? w_be : 4'b0000;
    assign mem_addr  = mem_req ? w_beat_addr : '0;
    assign mem_wdata = mem_we ? w_wdata : '0;

    assign resp_err  = resp_valid & r_err;
    assign resp_data = (resp_valid && !r_err && r_load) ? w_ext : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Directed self-checking bench for lsu_ctrl with a bus
//                responder that records each granted beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_fn3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks;
    int n_fail;

    // Observations from the most recent access
    logic [31:0] obs_addr  [2];
    logic [31:0] obs_be    [2];
    logic [31:0] obs_wdata [2];
    logic [31:0] obs_we    [2];
    int          n_beats;
    int          n_resp;
    int          resp_lat;
    logic [31:0] obs_data;
    logic [31:0] obs_err;
    logic        ready_early;
    logic        unstable;

    lsu_ctrl #(
        .XLEN   (32),
        .ADDR_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_fn3    (req_fn3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, then act as the bus for a fixed window: grant after
    // gnt_wait stalled cycles, return read data the cycle after each grant.
    task automatic access(input logic ld, input logic st, input logic [2:0] fn3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd0, input logic [31:0] rd1,
                          input int gnt_wait);
        int          wait_cnt;
        logic        rv_pend;
        logic [31:0] ref_addr;
        logic [31:0] ref_wdata;
        logic [3:0]  ref_be;
        logic        ref_we;
        req_valid = 1'b1;
        req_load  = ld;
        req_store = st;
        req_fn3   = fn3;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid   = 1'b0;
        n_beats     = 0;
        n_resp      = 0;
        resp_lat    = -1;
        obs_data    = 32'hxxxx_xxxx;
        obs_err     = 32'hxxxx_xxxx;
        ready_early = 1'b0;
        unstable    = 1'b0;
        wait_cnt    = 0;
        rv_pend     = 1'b0;
        ref_addr    = '0;
        ref_wdata   = '0;
        ref_be      = '0;
        ref_we      = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (resp_valid) begin
                n_resp++;
                if (resp_lat < 0) begin
                    resp_lat = cyc;
                    obs_data = resp_data;
                    obs_err  = {31'b0, resp_err};
                end
            end
            if (req_ready && n_resp == 0) ready_early = 1'b1;
            if (rv_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (n_beats == 1) ? rd0 : rd1;
                rv_pend    = 1'b0;
            end
            if (mem_req) begin
                if (wait_cnt == 0) begin
                    ref_addr  = mem_addr;
                    ref_wdata = mem_wdata;
                    ref_be    = mem_be;
                    ref_we    = mem_we;
                end else if (mem_addr !== ref_addr || mem_wdata !== ref_wdata ||
                             mem_be !== ref_be || mem_we !== ref_we) begin
                    unstable = 1'b1;
                end
                if (wait_cnt >= gnt_wait) begin
                    mem_gnt = 1'b1;
                    if (n_beats < 2) begin
                        obs_addr[n_beats]  = mem_addr;
                        obs_be[n_beats]    = {28'b0, mem_be};
                        obs_wdata[n_beats] = mem_wdata;
                        obs_we[n_beats]    = {31'b0, mem_we};
                    end
                    n_beats++;
                    wait_cnt = 0;
                    if (!mem_we) rv_pend = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
            tick();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [31:0] we,
                              input logic [31:0] addr, input logic [31:0] be,
                              input logic [31:0] wd);
        check({tag, "_we"},    obs_we[idx],    we);
        check({tag, "_addr"},  obs_addr[idx],  addr);
        check({tag, "_be"},    obs_be[idx],    be);
        check({tag, "_wdata"}, obs_wdata[idx], wd);
    endtask

    task automatic check_resp(input string tag, input int beats, input int lat,
                              input logic [31:0] data, input logic [31:0] err);
        check({tag, "_beats"},  n_beats,            beats);
        check({tag, "_nresp"},  n_resp,             1);
        check({tag, "_lat"},    resp_lat,           lat);
        check({tag, "_data"},   obs_data,           data);
        check({tag, "_err"},    obs_err,            err);
        check({tag, "_ready"},  {31'b0, ready_early}, 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
        req_fn3    = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset state
        tick();
        tick();
        check("rst_ready",  {31'b0, req_ready},  32'd1);
        check("rst_memreq", {31'b0, mem_req},    32'd0);
        check("rst_we",     {31'b0, mem_we},     32'd0);
        check("rst_be",     {28'b0, mem_be},     32'd0);
        check("rst_addr",   mem_addr,            32'd0);
        check("rst_wdata",  mem_wdata,           32'd0);
        check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata",  resp_data,           32'd0);
        check("rst_err",    {31'b0, resp_err},   32'd0);
        rst_n = 1'b1;
        tick();

        // Aligned LW
        access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0, 0);
        check_beat("lw_b0", 0, 32'd0, 32'h0000_0100, 32'hF, 32'h0);
        check_resp("lw", 1, 3, 32'hDEAD_BEEF, 32'd0);

        // LB / LBU top lane
        access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 32'h0, 0);
        check_beat("lb_b0", 0, 32'd0, 32'h0000_0100, 32'h8, 32'h0);
        check_resp("lb", 1, 3, 32'hFFFF_FF80, 32'd0);
        access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 32'h0, 0);
        check_resp("lbu", 1, 3, 32'h0000_0080, 32'd0);

        // Misaligned SW across a word boundary
        access(1'b0, 1'b1, 3'b010, 32'h0000_01FE, 32'h1122_3344, 32'h0, 32'h0, 0);
        check_beat("sw_b0", 0, 32'd1, 32'h0000_01FC, 32'hC, 32'h3344_0000);
        check_beat("sw_b1", 1, 32'd1, 32'h0000_0200, 32'h3, 32'h0000_1122);
        check_resp("sw", 2, 3, 32'h0, 32'd0);

        // Misaligned LH, sign-extended
        access(1'b1, 1'b0, 3'b001, 32'h0000_0007, 32'h0, 32'hAB00_0000, 32'h0000_00CD, 0);
        check_beat("lh_b0", 0, 32'd0, 32'h0000_0004, 32'h8, 32'h0);
        check_beat("lh_b1", 1, 32'd0, 32'h0000_0008, 32'h1, 32'h0);
        check_resp("lh", 2, 5, 32'hFFFF_CDAB, 32'd0);

        // Misaligned LHU, zero-extended
        access(1'b1, 1'b0, 3'b101, 32'h0000_0013, 32'h0, 32'h7F00_0000, 32'h0000_0080, 0);
        check_resp("lhu", 2, 5, 32'h0000_807F, 32'd0);

        // Aligned-within-word SH and SB
        access(1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h0000_BEEF, 32'h0, 32'h0, 0);
        check_beat("sh_b0", 0, 32'd1, 32'h0000_0040, 32'hC, 32'hBEEF_0000);
        check_resp("sh", 1, 2, 32'h0, 32'd0);
        access(1'b0, 1'b1, 3'b000, 32'h0000_0033, 32'h0000_00A5, 32'h0, 32'h0, 0);
        check_beat("sb_b0", 0, 32'd1, 32'h0000_0030, 32'h8, 32'hA500_0000);
        check_resp("sb", 1, 2, 32'h0, 32'd0);

        // Split store at the top of the address space wraps to zero
        access(1'b0, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'h0, 32'h0, 0);
        check_beat("wrap_b0", 0, 32'd1, 32'hFFFF_FFFC, 32'h8, 32'hDD00_0000);
        check_beat("wrap_b1", 1, 32'd1, 32'h0000_0000, 32'h7, 32'h00AA_BBCC);
        check_resp("wrap", 2, 3, 32'h0, 32'd0);

        // Illegal requests never touch the bus
        access(1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 0);
        check_resp("ill_ld3", 0, 1, 32'h0, 32'd1);
        access(1'b0, 1'b1, 3'b100, 32'h0000_0040, 32'h1234_5678, 32'h0, 32'h0, 0);
        check_resp("ill_st4", 0, 1, 32'h0, 32'd1);
        access(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 0);
        check_resp("ill_both", 0, 1, 32'h0, 32'd1);

        // Grant withheld for 5 cycles: bus fields must hold
        access(1'b0, 1'b1, 3'b010, 32'h0000_0080, 32'hCAFE_F00D, 32'h0, 32'h0, 5);
        check("stall_stable", {31'b0, unstable}, 32'd0);
        check_beat("stall_b0", 0, 32'd1, 32'h0000_0080, 32'hF, 32'hCAFE_F00D);
        check_resp("stall", 1, 7, 32'h0, 32'd0);

        // Reset while waiting for read data
        req_valid = 1'b1;
        req_load  = 1'b1;
        req_store = 1'b0;
        req_fn3   = 3'b010;
        req_addr  = 32'h0000_0300;
        tick();
        req_valid = 1'b0;
        check("rst_mid_req", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("rst_mid_wait", {31'b0, mem_req}, 32'd0);
        rst_n = 1'b0;
        #2;
        check("rst_mid_ready", {31'b0, req_ready},  32'd1);
        check("rst_mid_resp",  {31'b0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 1'b0;
        check("stale_resp",  {31'b0, resp_valid}, 32'd0);
        check("stale_ready", {31'b0, req_ready},  32'd1);
        check("stale_req",   {31'b0, mem_req},    32'd0);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h1234_5678, 32'h0, 0);
        check_beat("post_b0", 0, 32'd0, 32'h0000_0104, 32'hF, 32'h0);
        check_resp("post", 1, 3, 32'h1234_5678, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
